// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared RV32I execute-stage encodings
//
// Purpose: ALU operation codes, hazard-unit forwarding select codes and the
//          execute-stage trap FSM state type shared by execute_cycle and alu.
// Ports:   none (package).
package rv32_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 5;

  // ALU operation codes driven by decode on ALUControlE.
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Forwarding selects from the hazard unit; 2'b11 falls back to the register file.
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {
    EX_RUN  = 1'b0,
    EX_TRAP = 1'b1
  } ex_state_t;

endpackage

// File: rtl/execute_cycle_alu.sv
// rtl/execute_cycle_alu.sv - combinational RV32I ALU for the execute stage
//
// Purpose: computes add/sub/and/or/signed-slt on two operands. Unlisted
//          operation codes return zero. Zero always reflects SrcA - SrcB,
//          whatever the selected operation, so branch compare does not depend
//          on decode choosing ALU_SUB.
// Ports:
//   SrcA, SrcB   in  DATA_W  operands
//   ALUControl   in  3       operation code (rv32_pkg ALU_*)
//   Result       out DATA_W  operation result
//   Zero         out 1       (SrcA - SrcB) == 0
module alu
  import rv32_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] SrcA,
  input  logic [DATA_W-1:0] SrcB,
  input  logic [2:0]        ALUControl,
  output logic [DATA_W-1:0] Result,
  output logic              Zero
);

  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;
  logic              lt_signed;

  // Both wrap naturally at 2^DATA_W; carries are discarded.
  assign sum       = SrcA + SrcB;
  assign diff      = SrcA - SrcB;
  assign lt_signed = $signed(SrcA) < $signed(SrcB);

  always_comb begin
    Result = '0;
    case (ALUControl)
      ALU_ADD: Result = sum;
      ALU_SUB: Result = diff;
      ALU_AND: Result = SrcA & SrcB;
      ALU_OR:  Result = SrcA | SrcB;
      ALU_SLT: Result = {{(DATA_W-1){1'b0}}, lt_signed};
      default: Result = '0;
    endcase
  end

  assign Zero = (diff == '0);

endmodule

// File: rtl/execute_cycle.sv
// rtl/execute_cycle.sv - RV32I EX stage: forwarding, ALU, branch, EX/MEM register, trap FSM
//
// Purpose: consumes ID/EX register outputs, applies hazard-unit forwarding,
//          runs the ALU, resolves branches and registers results into EX/MEM.
//          A sticky trap FSM kills all architectural side effects from the
//          first illegal instruction until reset.
// Build option: EXEC_PERF_CNT_EN adds RetireCnt and BranchTakenCnt counters.
// Ports:
//   clk, rst (async active-low)
//   RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE   ID/EX control
//   RD1_E, RD2_E, ImmExt_E, PCE, PCPlus4E, RD_E                        ID/EX data
//   IllegalOpE                                                        decode illegal flag
//   ForwardA_E, ForwardB_E, ResultW                                   forwarding
//   PCSrcE, PCTargetE                                                 branch (combinational)
//   RegWriteM, MemWriteM, ResultSrcM, RD_M, ALUResultM, WriteDataM,
//   PCPlus4M                                                          EX/MEM register
//   TrapM, TrapPC, Halt                                               trap status
//   RetireCnt, BranchTakenCnt (EXEC_PERF_CNT_EN only)                 performance counters
module execute_cycle
  import rv32_pkg::*;
#(
  parameter int DATA_W          = 32,
  parameter int REG_AW          = 5,
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteE,
  input  logic              ALUSrcE,
  input  logic              MemWriteE,
  input  logic              ResultSrcE,
  input  logic              BranchE,
  input  logic [2:0]        ALUControlE,
  input  logic [DATA_W-1:0] RD1_E,
  input  logic [DATA_W-1:0] RD2_E,
  input  logic [DATA_W-1:0] ImmExt_E,
  input  logic [DATA_W-1:0] PCE,
  input  logic [DATA_W-1:0] PCPlus4E,
  input  logic [REG_AW-1:0] RD_E,
  input  logic              IllegalOpE,
  input  logic [1:0]        ForwardA_E,
  input  logic [1:0]        ForwardB_E,
  input  logic [DATA_W-1:0] ResultW,
  output logic              PCSrcE,
  output logic [DATA_W-1:0] PCTargetE,
  output logic              RegWriteM,
  output logic              MemWriteM,
  output logic              ResultSrcM,
  output logic [REG_AW-1:0] RD_M,
  output logic [DATA_W-1:0] ALUResultM,
  output logic [DATA_W-1:0] WriteDataM,
  output logic [DATA_W-1:0] PCPlus4M,
  output logic              TrapM,
  output logic [DATA_W-1:0] TrapPC,
  output logic              Halt
`ifdef EXEC_PERF_CNT_EN
  ,
  output logic [31:0]       RetireCnt,
  output logic [31:0]       BranchTakenCnt
`endif
);

  ex_state_t         state_q;

  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] fwd_b;
  logic [DATA_W-1:0] src_b;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  logic              kill;
  logic              branch_taken;

  logic              reg_write_d,   reg_write_q;
  logic              mem_write_d,   mem_write_q;
  logic              result_src_q;
  logic [REG_AW-1:0] rd_q;
  logic [DATA_W-1:0] alu_result_q;
  logic [DATA_W-1:0] write_data_q;
  logic [DATA_W-1:0] pc_plus4_q;
  logic              trap_m_q;
  logic [DATA_W-1:0] trap_pc_q;
  logic              halt_q;

  // ---------------------------------------------------------------------------
  // Forwarding. The MEM source is the registered EX/MEM ALU result, i.e. the
  // instruction one ahead, not this cycle's ALU output.
  // ---------------------------------------------------------------------------
  always_comb begin
    src_a = RD1_E;
    case (ForwardA_E)
      FWD_WB:  src_a = ResultW;
      FWD_MEM: src_a = alu_result_q;
      default: src_a = RD1_E;
    endcase
  end

  always_comb begin
    fwd_b = RD2_E;
    case (ForwardB_E)
      FWD_WB:  fwd_b = ResultW;
      FWD_MEM: fwd_b = alu_result_q;
      default: fwd_b = RD2_E;
    endcase
  end

  assign src_b = ALUSrcE ? ImmExt_E : fwd_b;

  alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .SrcA       (src_a),
    .SrcB       (src_b),
    .ALUControl (ALUControlE),
    .Result     (alu_result),
    .Zero       (alu_zero)
  );

  // ---------------------------------------------------------------------------
  // Branch resolution. An illegal instruction never redirects fetch, and
  // nothing redirects once trapped.
  // ---------------------------------------------------------------------------
  assign kill         = (state_q == EX_TRAP) | IllegalOpE;
  assign branch_taken = BranchE & alu_zero & (state_q == EX_RUN) & ~IllegalOpE;
  assign PCSrcE       = branch_taken;
  assign PCTargetE    = PCE + ImmExt_E;

  // ---------------------------------------------------------------------------
  // EX/MEM pipeline register: captures every cycle; only the write enables
  // are squashed by kill so data fields stay observable for debug.
  // ---------------------------------------------------------------------------
  assign reg_write_d = RegWriteE & ~kill;
  assign mem_write_d = MemWriteE & ~kill;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      result_src_q <= 1'b0;
      rd_q         <= '0;
      alu_result_q <= '0;
      write_data_q <= '0;
      pc_plus4_q   <= '0;
    end else begin
      reg_write_q  <= reg_write_d;
      mem_write_q  <= mem_write_d;
      result_src_q <= ResultSrcE;
      rd_q         <= RD_E;
      alu_result_q <= alu_result;
      write_data_q <= fwd_b;
      pc_plus4_q   <= PCPlus4E;
    end
  end

  // ---------------------------------------------------------------------------
  // Trap FSM. TRAP is sticky until reset; TrapPC holds the first illegal PC
  // and later illegal instructions are ignored.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= EX_RUN;
      trap_m_q  <= 1'b0;
      trap_pc_q <= '0;
      halt_q    <= 1'b0;
    end else begin
      case (state_q)
        EX_RUN: begin
          if (IllegalOpE && TRAP_ON_ILLEGAL) begin
            state_q   <= EX_TRAP;
            trap_m_q  <= 1'b1;
            trap_pc_q <= PCE;
            halt_q    <= 1'b1;
          end else begin
            trap_m_q  <= 1'b0;
          end
        end
        EX_TRAP: begin
          trap_m_q <= 1'b0;
          halt_q   <= 1'b1;
        end
        default: begin
          state_q  <= EX_RUN;
          trap_m_q <= 1'b0;
        end
      endcase
    end
  end

  assign RegWriteM  = reg_write_q;
  assign MemWriteM  = mem_write_q;
  assign ResultSrcM = result_src_q;
  assign RD_M       = rd_q;
  assign ALUResultM = alu_result_q;
  assign WriteDataM = write_data_q;
  assign PCPlus4M   = pc_plus4_q;
  assign TrapM      = trap_m_q;
  assign TrapPC     = trap_pc_q;
  assign Halt       = halt_q;

`ifdef EXEC_PERF_CNT_EN
  // ---------------------------------------------------------------------------
  // Performance counters. kill already covers TRAP, so both freeze there.
  // ---------------------------------------------------------------------------
  logic [31:0] retire_cnt_q,  retire_cnt_d;
  logic [31:0] branch_cnt_q,  branch_cnt_d;

  assign retire_cnt_d = retire_cnt_q +
                        {31'd0, ~kill & (RegWriteE | MemWriteE | BranchE)};
  assign branch_cnt_d = branch_cnt_q + {31'd0, branch_taken};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retire_cnt_q <= '0;
      branch_cnt_q <= '0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
      branch_cnt_q <= branch_cnt_d;
    end
  end

  assign RetireCnt      = retire_cnt_q;
  assign BranchTakenCnt = branch_cnt_q;
`endif

endmodule

// File: tb/tb_execute_cycle.sv
// tb/tb_execute_cycle.sv - directed self-checking bench for execute_cycle
module tb_execute_cycle;

  logic        clk;
  logic        rst;
  logic        RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1_E, RD2_E, ImmExt_E, PCE, PCPlus4E;
  logic [4:0]  RD_E;
  logic        IllegalOpE;
  logic [1:0]  ForwardA_E, ForwardB_E;
  logic [31:0] ResultW;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        RegWriteM, MemWriteM, ResultSrcM;
  logic [4:0]  RD_M;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic        TrapM;
  logic [31:0] TrapPC;
  logic        Halt;
`ifdef EXEC_PERF_CNT_EN
  logic [31:0] RetireCnt, BranchTakenCnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  execute_cycle dut (
    .clk         (clk),
    .rst         (rst),
    .RegWriteE   (RegWriteE),
    .ALUSrcE     (ALUSrcE),
    .MemWriteE   (MemWriteE),
    .ResultSrcE  (ResultSrcE),
    .BranchE     (BranchE),
    .ALUControlE (ALUControlE),
    .RD1_E       (RD1_E),
    .RD2_E       (RD2_E),
    .ImmExt_E    (ImmExt_E),
    .PCE         (PCE),
    .PCPlus4E    (PCPlus4E),
    .RD_E        (RD_E),
    .IllegalOpE  (IllegalOpE),
    .ForwardA_E  (ForwardA_E),
    .ForwardB_E  (ForwardB_E),
    .ResultW     (ResultW),
    .PCSrcE      (PCSrcE),
    .PCTargetE   (PCTargetE),
    .RegWriteM   (RegWriteM),
    .MemWriteM   (MemWriteM),
    .ResultSrcM  (ResultSrcM),
    .RD_M        (RD_M),
    .ALUResultM  (ALUResultM),
    .WriteDataM  (WriteDataM),
    .PCPlus4M    (PCPlus4M),
    .TrapM       (TrapM),
    .TrapPC      (TrapPC),
    .Halt        (Halt)
`ifdef EXEC_PERF_CNT_EN
    ,
    .RetireCnt      (RetireCnt),
    .BranchTakenCnt (BranchTakenCnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    RegWriteE = 0; ALUSrcE = 0; MemWriteE = 0; ResultSrcE = 0; BranchE = 0;
    ALUControlE = 3'b000;
    RD1_E = 0; RD2_E = 0; ImmExt_E = 0; PCE = 0; PCPlus4E = 0; RD_E = 0;
    IllegalOpE = 0; ForwardA_E = 2'b00; ForwardB_E = 2'b00; ResultW = 0;
  endtask

  // Advance one rising edge and sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_alu",   ALUResultM, 32'h0);
    chk("rst_regw",  RegWriteM,  32'h0);
    chk("rst_halt",  Halt,       32'h0);
    chk("rst_trapm", TrapM,      32'h0);
    chk("rst_trappc",TrapPC,     32'h0);
    rst = 1'b1;

    // add with WB forwarding on B: 5 + 7
    @(negedge clk);
    RD1_E = 32'd5; RD2_E = 32'd99; ForwardB_E = 2'b01; ResultW = 32'd7;
    ALUControlE = 3'b000; RegWriteE = 1; RD_E = 5'd3; PCPlus4E = 32'h20;
    step();
    chk("add_res",   ALUResultM, 32'd12);
    chk("add_wd",    WriteDataM, 32'd7);
    chk("add_regw",  RegWriteM,  32'h1);
    chk("add_rd",    RD_M,       32'd3);
    chk("add_pc4",   PCPlus4M,   32'h20);
    chk("add_memw",  MemWriteM,  32'h0);

    // sub wrapping: 0 - 1 = FFFFFFFF (no side effects)
    clear_inputs();
    RD1_E = 32'd0; RD2_E = 32'd1; ALUControlE = 3'b001;
    step();
    chk("sub_wrap",  ALUResultM, 32'hFFFF_FFFF);
    chk("sub_regw",  RegWriteM,  32'h0);

    // signed slt with MEM forwarding on A: -1 < 1 -> 1
    clear_inputs();
    ForwardA_E = 2'b10; RD1_E = 32'd123; RD2_E = 32'd1; ALUControlE = 3'b101;
    step();
    chk("slt_mem",   ALUResultM, 32'h1);
    chk("slt_wd",    WriteDataM, 32'h1);

    // and / or with immediate operand, unlisted opcode gives 0
    clear_inputs();
    RD1_E = 32'h0000_F0F0; ALUSrcE = 1; ImmExt_E = 32'h0000_0FF0; ALUControlE = 3'b010;
    step();
    chk("and_imm",   ALUResultM, 32'h0000_00F0);
    ALUControlE = 3'b011;
    step();
    chk("or_imm",    ALUResultM, 32'h0000_FFF0);
    ALUControlE = 3'b111;
    step();
    chk("op_undef",  ALUResultM, 32'h0);

    // Branch taken with ALUControl=add: Zero is still SrcA-SrcB
    clear_inputs();
    BranchE = 1; RD1_E = 32'd9; RD2_E = 32'd9; PCE = 32'h100; ImmExt_E = 32'hFFFF_FFF8;
    #1;
    chk("br_taken",  PCSrcE,     32'h1);
    chk("br_target", PCTargetE,  32'h0000_00F8);
    step();
    chk("br_alu",    ALUResultM, 32'd18);

    // Branch not taken
    RD2_E = 32'd8;
    #1;
    chk("br_ntaken", PCSrcE,     32'h0);
    step();
`ifdef EXEC_PERF_CNT_EN
    chk("perf_ret",  RetireCnt,      32'd3);
    chk("perf_br",   BranchTakenCnt, 32'd1);
`endif

    // Illegal op at 0x40 with RegWrite and a would-be-taken branch
    clear_inputs();
    IllegalOpE = 1; PCE = 32'h40; RegWriteE = 1; BranchE = 1;
    RD1_E = 32'd4; RD2_E = 32'd4;
    #1;
    chk("ill_pcsrc", PCSrcE,     32'h0);
    step();
    chk("ill_trapm", TrapM,      32'h1);
    chk("ill_trappc",TrapPC,     32'h40);
    chk("ill_halt",  Halt,       32'h1);
    chk("ill_regw",  RegWriteM,  32'h0);

    // Valid store afterwards: killed, TrapM drops, no branch
    clear_inputs();
    MemWriteE = 1; PCE = 32'h44; BranchE = 1; RD1_E = 32'd2; RD2_E = 32'd2;
    #1;
    chk("trap_pcsrc",PCSrcE,     32'h0);
    step();
    chk("st_trapm",  TrapM,      32'h0);
    chk("st_memw",   MemWriteM,  32'h0);
    chk("st_halt",   Halt,       32'h1);

    // Second illegal op ignored; TrapPC frozen
    clear_inputs();
    IllegalOpE = 1; PCE = 32'h80; RegWriteE = 1;
    step();
    chk("ill2_pc",   TrapPC,     32'h40);
    chk("ill2_trapm",TrapM,      32'h0);
    chk("ill2_halt", Halt,       32'h1);
`ifdef EXEC_PERF_CNT_EN
    chk("perf_ret_frz", RetireCnt,      32'd3);
    chk("perf_br_frz",  BranchTakenCnt, 32'd1);
`endif

    // Mid-stream asynchronous reset with non-zero inputs
    clear_inputs();
    RD1_E = 32'h11; RD2_E = 32'h22; RegWriteE = 1; RD_E = 5'd7; PCPlus4E = 32'h104;
    step();
    chk("pre_rst_alu", ALUResultM, 32'h33);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_alu",   ALUResultM, 32'h0);
    chk("arst_wd",    WriteDataM, 32'h0);
    chk("arst_pc4",   PCPlus4M,   32'h0);
    chk("arst_rd",    RD_M,       32'h0);
    chk("arst_halt",  Halt,       32'h0);
    chk("arst_trappc",TrapPC,     32'h0);
`ifdef EXEC_PERF_CNT_EN
    chk("arst_ret",   RetireCnt,  32'h0);
`endif
    @(negedge clk);
    rst = 1'b1;
    step();
    chk("resume_alu", ALUResultM, 32'h33);
    chk("resume_regw",RegWriteM,  32'h1);
    chk("resume_rd",  RD_M,       32'd7);
    chk("resume_halt",Halt,       32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
